// File: rtl/ser_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package ser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } ser_state_t;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;
    localparam logic LINE_STOP  = 1'b0;

endpackage

// File: rtl/serial_frame_tx.sv
// Parallel-in/serial-out framer: start bit, data MSB-first, optional even parity, stop bit.
// Line outputs are registered copies of the current state's decode, so a word
// accepted at edge T shows its start bit on x_o from edge T+1.
module serial_frame_tx
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W    = 4,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              x_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    ser_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_hold;
    logic               r_x;
    logic               r_busy;
    logic               r_done;
    logic               r_ready;

    ser_state_t         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]  w_hold_nxt;
    logic               w_x_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_ready_nxt;
    logic               w_xfer;

    assign w_xfer = valid_i && r_ready;

    // Next-state, counter/hold update and per-state line decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_x_nxt     = LINE_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_x_nxt = LINE_IDLE;
                if (w_xfer) begin
                    w_state_nxt = START;
                    w_hold_nxt  = data_i;
                end
            end
            START: begin
                w_x_nxt     = LINE_START;
                w_busy_nxt  = 1'b1;
                w_cnt_nxt   = CNT_W'(DATA_W - 1);
                w_state_nxt = DATA;
            end
            DATA: begin
                w_x_nxt    = r_hold[r_cnt];
                w_busy_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = PARITY_EN ? PARITY : STOP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            PARITY: begin
                w_x_nxt     = ^r_hold;
                w_busy_nxt  = 1'b1;
                w_state_nxt = STOP;
            end
            STOP: begin
                w_x_nxt    = LINE_STOP;
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b1;
                if (w_xfer) begin
                    w_state_nxt = START;
                    w_hold_nxt  = data_i;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == STOP);
    end

    // State, counter, hold register and output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_x     <= LINE_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_x     <= w_x_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign x_o     = r_x;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign ready_o = r_ready;

endmodule
